// File: rtl/text_anim_ctrl_if.sv
// text_anim_ctrl_if
//   Groups the frame strobe, control requests and overlay outputs of
//   text_anim_ctrl into one bundle.
//   master : drives next_frame/start/abort, observes the overlay outputs
//   slave  : the sequencer side (text_anim_ctrl)
//   Signals:
//     next_frame  1-cycle pulse per frame (vertical blank)
//     start       1-cycle request to begin the intro
//     abort       1-cycle request to return to IDLE
//     base_y[9:0] line-0 top Y coordinate
//     text_en     text visible
//     busy        sequence in progress
//     done        1-cycle pulse on entry to SHOWN
//     state_o[2:0] current state, for debug
interface text_anim_ctrl_if;
    logic       next_frame;
    logic       start;
    logic       abort;
    logic [9:0] base_y;
    logic       text_en;
    logic       busy;
    logic       done;
    logic [2:0] state_o;

    modport master (
        output next_frame, start, abort,
        input  base_y, text_en, busy, done, state_o
    );

    modport slave (
        input  next_frame, start, abort,
        output base_y, text_en, busy, done, state_o
    );
endinterface

// File: rtl/text_anim_ctrl.sv
// text_anim_ctrl
//   Frame-rate sequencer for the foreground text overlay. One-shot intro:
//   drop in from START_Y to TARGET_Y, optional bounce, hold, blink, then
//   stay shown. All outputs are registered.
//   Ports:
//     clk  system/pixel clock
//     rst  asynchronous, active-high reset
//     ctl  text_anim_ctrl_if.slave (next_frame/start/abort in,
//          base_y/text_en/busy/done/state_o out)
//   Build option:
//     TEXT_ANIM_BOUNCE_EN  when defined, DROP exits into a BOUNCE state
//                          (down BOUNCE_H pixels and back, 2 px per frame);
//                          otherwise DROP exits straight into HOLD.
module text_anim_ctrl #(
    parameter logic [9:0] START_Y     = 10'd0,
    parameter logic [9:0] TARGET_Y    = 10'd336,
    parameter logic [9:0] FALL_STEP   = 10'd4,
    parameter logic [7:0] HOLD_FRAMES = 8'd120,
    parameter logic [5:0] BLINK_HALF  = 6'd8,
    parameter logic [2:0] BLINK_COUNT = 3'd3,
    parameter logic [9:0] BOUNCE_H    = 10'd8
) (
    input  logic             clk,
    input  logic             rst,
    text_anim_ctrl_if.slave  ctl
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DROP   = 3'd1,
        S_BOUNCE = 3'd2,
        S_HOLD   = 3'd3,
        S_BLINK  = 3'd4,
        S_SHOWN  = 3'd5
    } state_e;

    localparam logic [10:0] TARGET_W    = {1'b0, TARGET_Y};
    localparam logic [7:0]  HOLD_LAST   = HOLD_FRAMES - 8'd1;
    localparam logic [7:0]  HALF_LAST   = {2'b00, BLINK_HALF} - 8'd1;
    localparam logic [2:0]  BLINKS_LAST = BLINK_COUNT - 3'd1;

`ifdef TEXT_ANIM_BOUNCE_EN
    localparam logic [9:0]  BOUNCE_LOW  = TARGET_Y - BOUNCE_H;
    // A zero-height bounce would never reach its turning point; skip it.
    localparam state_e      DROP_EXIT   = (BOUNCE_H != 10'd0) ? S_BOUNCE : S_HOLD;
`else
    localparam state_e      DROP_EXIT   = S_HOLD;
`endif

    state_e      state_q, state_d;
    logic [9:0]  base_y_q, base_y_d;
    logic        text_en_q, text_en_d;
    logic        done_q, done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [2:0]  blink_cnt_q, blink_cnt_d;

    // Frame-event decode shared by next-state and output logic.
    logic [10:0] drop_sum;
    logic        drop_hit;
    logic        hold_end;
    logic        half_end;
    logic        blink_last;

    assign drop_sum   = {1'b0, base_y_q} + {1'b0, FALL_STEP};
    assign drop_hit   = (drop_sum >= TARGET_W);
    assign hold_end   = (frame_cnt_q == HOLD_LAST);
    assign half_end   = (frame_cnt_q == HALF_LAST);
    assign blink_last = (blink_cnt_q == BLINKS_LAST);

`ifdef TEXT_ANIM_BOUNCE_EN
    logic        rising_q, rising_d;
    logic [9:0]  bounce_dn;
    logic [9:0]  bounce_up;
    logic        bounce_turn;
    logic        bounce_end;

    assign bounce_dn   = base_y_q - 10'd2;
    assign bounce_up   = base_y_q + 10'd2;
    assign bounce_turn = !rising_q && (bounce_dn == BOUNCE_LOW);
    assign bounce_end  = rising_q && (bounce_up == TARGET_Y);
`endif

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_y_q    <= START_Y;
            text_en_q   <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
`ifdef TEXT_ANIM_BOUNCE_EN
            rising_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_y_q    <= base_y_d;
            text_en_q   <= text_en_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
`ifdef TEXT_ANIM_BOUNCE_EN
            rising_q    <= rising_d;
`endif
        end
    end

    // Next-state logic; abort overrides every other request.
    always_comb begin
        state_d = state_q;
        if (ctl.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (ctl.start) state_d = S_DROP;
                S_DROP:   if (ctl.next_frame && drop_hit) state_d = DROP_EXIT;
`ifdef TEXT_ANIM_BOUNCE_EN
                S_BOUNCE: if (ctl.next_frame && bounce_end) state_d = S_HOLD;
`endif
                S_HOLD:   if (ctl.next_frame && hold_end) state_d = S_BLINK;
                // Leave BLINK only at the end of the last on-phase.
                S_BLINK:  if (ctl.next_frame && half_end && text_en_q && blink_last)
                              state_d = S_SHOWN;
                S_SHOWN:  if (ctl.start) state_d = S_DROP;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output / datapath logic computing the next registered output values.
    always_comb begin
        base_y_d    = base_y_q;
        text_en_d   = text_en_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
`ifdef TEXT_ANIM_BOUNCE_EN
        rising_d    = rising_q;
`endif
        done_d      = (state_d == S_SHOWN) && (state_q != S_SHOWN);

        if (ctl.abort) begin
            base_y_d    = START_Y;
            text_en_d   = 1'b0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
`ifdef TEXT_ANIM_BOUNCE_EN
            rising_d    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // base_y already sits at START_Y; a coincident frame
                    // pulse must not move it.
                    if (ctl.start) text_en_d = 1'b1;
                end
                S_DROP: begin
                    if (ctl.next_frame) begin
                        if (drop_hit) begin
                            base_y_d    = TARGET_Y;
                            frame_cnt_d = '0;
`ifdef TEXT_ANIM_BOUNCE_EN
                            rising_d    = 1'b0;
`endif
                        end else begin
                            base_y_d = drop_sum[9:0];
                        end
                    end
                end
`ifdef TEXT_ANIM_BOUNCE_EN
                S_BOUNCE: begin
                    if (ctl.next_frame) begin
                        if (rising_q) begin
                            base_y_d = bounce_up;
                        end else begin
                            base_y_d = bounce_dn;
                        end
                        if (bounce_turn) rising_d = 1'b1;
                        if (bounce_end)  frame_cnt_d = '0;
                    end
                end
`endif
                S_HOLD: begin
                    if (ctl.next_frame) begin
                        if (hold_end) begin
                            frame_cnt_d = '0;
                            blink_cnt_d = '0;
                            text_en_d   = 1'b0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                S_BLINK: begin
                    if (ctl.next_frame) begin
                        if (half_end) begin
                            frame_cnt_d = '0;
                            if (!text_en_q) begin
                                text_en_d = 1'b1;
                            end else if (!blink_last) begin
                                blink_cnt_d = blink_cnt_q + 3'd1;
                                text_en_d   = 1'b0;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end
                end
                S_SHOWN: begin
                    if (ctl.start) begin
                        base_y_d    = START_Y;
                        text_en_d   = 1'b1;
                        frame_cnt_d = '0;
                        blink_cnt_d = '0;
                    end
                end
                default: begin
                    base_y_d  = START_Y;
                    text_en_d = 1'b0;
                end
            endcase
        end
    end

    assign ctl.base_y  = base_y_q;
    assign ctl.text_en = text_en_q;
    assign ctl.done    = done_q;
    assign ctl.state_o = state_q;
    assign ctl.busy    = (state_q == S_DROP) || (state_q == S_BOUNCE) ||
                         (state_q == S_HOLD) || (state_q == S_BLINK);

endmodule

// File: tb/tb_text_anim_ctrl.sv
// tb_text_anim_ctrl
//   Directed bench for text_anim_ctrl. Instance a uses default parameters;
//   instance b uses FALL_STEP=5. Works with or without TEXT_ANIM_BOUNCE_EN.
module tb_text_anim_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    text_anim_ctrl_if a_if();
    text_anim_ctrl_if b_if();

    text_anim_ctrl u_a (
        .clk (clk),
        .rst (rst),
        .ctl (a_if)
    );

    text_anim_ctrl #(.FALL_STEP(10'd5)) u_b (
        .clk (clk),
        .rst (rst),
        .ctl (b_if)
    );

    int total = 0;
    int bad   = 0;

`ifdef TEXT_ANIM_BOUNCE_EN
    localparam int         BOUNCE_FR  = 8;
    localparam logic [2:0] AFTER_DROP = 3'd2;
`else
    localparam int         BOUNCE_FR  = 0;
    localparam logic [2:0] AFTER_DROP = 3'd3;
`endif

    // Stimulus helpers: each returns 1 time unit after the updating edge.
    task automatic a_frame();
        @(posedge clk); #1 a_if.next_frame = 1'b1;
        @(posedge clk); #1 a_if.next_frame = 1'b0;
    endtask

    task automatic a_frames(input int n);
        for (int i = 0; i < n; i++) a_frame();
    endtask

    task automatic a_start();
        @(posedge clk); #1 a_if.start = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0;
    endtask

    task automatic b_frame();
        @(posedge clk); #1 b_if.next_frame = 1'b1;
        @(posedge clk); #1 b_if.next_frame = 1'b0;
    endtask

    task automatic test_reset();
        a_if.next_frame = 1'b0; a_if.start = 1'b0; a_if.abort = 1'b0;
        b_if.next_frame = 1'b0; b_if.start = 1'b0; b_if.abort = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (a_if.base_y !== 10'd0) begin bad++; $display("FAIL reset_base_y got=%0d exp=0", a_if.base_y); end
        total++; if (a_if.text_en !== 1'b0) begin bad++; $display("FAIL reset_text_en got=%b exp=0", a_if.text_en); end
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", a_if.busy); end
        total++; if (a_if.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", a_if.done); end
        total++; if (a_if.state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", a_if.state_o); end
        rst = 1'b0;
        a_frames(3);
        total++; if (a_if.base_y !== 10'd0 || a_if.state_o !== 3'd0) begin
            bad++; $display("FAIL idle_frames base_y=%0d state=%0d exp=0/0", a_if.base_y, a_if.state_o);
        end
    endtask

    task automatic test_drop();
        // start with a coincident frame pulse: base_y must not move
        @(posedge clk); #1 a_if.start = 1'b1; a_if.next_frame = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0; a_if.next_frame = 1'b0;
        total++; if (a_if.base_y !== 10'd0) begin bad++; $display("FAIL start_base_y got=%0d exp=0", a_if.base_y); end
        total++; if (a_if.state_o !== 3'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", a_if.state_o); end
        total++; if (a_if.text_en !== 1'b1 || a_if.busy !== 1'b1) begin
            bad++; $display("FAIL start_flags text_en=%b busy=%b exp=1/1", a_if.text_en, a_if.busy);
        end
        for (int k = 1; k <= 83; k++) begin
            a_frame();
            total++; if (a_if.base_y !== 10'(4 * k)) begin
                bad++; $display("FAIL drop_base_y frame=%0d got=%0d exp=%0d", k, a_if.base_y, 4 * k);
            end
            if (k == 40) begin
                a_start();
                total++; if (a_if.base_y !== 10'd160 || a_if.state_o !== 3'd1) begin
                    bad++; $display("FAIL start_in_drop base_y=%0d state=%0d exp=160/1", a_if.base_y, a_if.state_o);
                end
            end
        end
        a_frame();
        total++; if (a_if.base_y !== 10'd336) begin bad++; $display("FAIL drop_clamp got=%0d exp=336", a_if.base_y); end
        total++; if (a_if.state_o !== AFTER_DROP) begin
            bad++; $display("FAIL drop_exit_state got=%0d exp=%0d", a_if.state_o, AFTER_DROP);
        end
    endtask

`ifdef TEXT_ANIM_BOUNCE_EN
    task automatic test_bounce();
        logic [9:0] exp_y [8] = '{10'd334, 10'd332, 10'd330, 10'd328,
                                  10'd330, 10'd332, 10'd334, 10'd336};
        for (int k = 0; k < 8; k++) begin
            a_frame();
            total++; if (a_if.base_y !== exp_y[k]) begin
                bad++; $display("FAIL bounce_y step=%0d got=%0d exp=%0d", k, a_if.base_y, exp_y[k]);
            end
        end
        total++; if (a_if.state_o !== 3'd3) begin bad++; $display("FAIL bounce_exit got=%0d exp=3", a_if.state_o); end
    endtask
`endif

    task automatic test_hold_blink();
        for (int k = 1; k <= 119; k++) begin
            a_frame();
            total++; if (a_if.state_o !== 3'd3 || a_if.text_en !== 1'b1) begin
                bad++; $display("FAIL hold frame=%0d state=%0d text_en=%b exp=3/1", k, a_if.state_o, a_if.text_en);
            end
        end
        a_frame();
        total++; if (a_if.state_o !== 3'd4 || a_if.text_en !== 1'b0 || a_if.busy !== 1'b1) begin
            bad++; $display("FAIL blink_entry state=%0d text_en=%b busy=%b exp=4/0/1", a_if.state_o, a_if.text_en, a_if.busy);
        end
        for (int f = 1; f <= 47; f++) begin
            a_frame();
            total++; if (a_if.text_en !== 1'(((f / 8) % 2) == 1) || a_if.state_o !== 3'd4 || a_if.done !== 1'b0) begin
                bad++; $display("FAIL blink frame=%0d text_en=%b state=%0d done=%b exp=%0d/4/0",
                                f, a_if.text_en, a_if.state_o, a_if.done, ((f / 8) % 2));
            end
        end
        a_frame();
        total++; if (a_if.done !== 1'b1) begin bad++; $display("FAIL shown_done got=%b exp=1", a_if.done); end
        total++; if (a_if.state_o !== 3'd5 || a_if.busy !== 1'b0 || a_if.text_en !== 1'b1 || a_if.base_y !== 10'd336) begin
            bad++; $display("FAIL shown_outputs state=%0d busy=%b text_en=%b base_y=%0d exp=5/0/1/336",
                            a_if.state_o, a_if.busy, a_if.text_en, a_if.base_y);
        end
        @(posedge clk); #1;
        total++; if (a_if.done !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", a_if.done); end
        a_frames(3);
        total++; if (a_if.state_o !== 3'd5 || a_if.base_y !== 10'd336 || a_if.done !== 1'b0) begin
            bad++; $display("FAIL shown_frames state=%0d base_y=%0d done=%b exp=5/336/0", a_if.state_o, a_if.base_y, a_if.done);
        end
    endtask

    task automatic test_restart();
        a_start();
        total++; if (a_if.base_y !== 10'd0 || a_if.text_en !== 1'b1 || a_if.busy !== 1'b1 || a_if.state_o !== 3'd1) begin
            bad++; $display("FAIL restart base_y=%0d text_en=%b busy=%b state=%0d exp=0/1/1/1",
                            a_if.base_y, a_if.text_en, a_if.busy, a_if.state_o);
        end
    endtask

    task automatic test_abort();
        a_frames(84 + BOUNCE_FR + 10);
        total++; if (a_if.state_o !== 3'd3) begin bad++; $display("FAIL pre_abort_state got=%0d exp=3", a_if.state_o); end
        @(posedge clk); #1 a_if.start = 1'b1; a_if.abort = 1'b1;
        @(posedge clk); #1 a_if.start = 1'b0; a_if.abort = 1'b0;
        total++; if (a_if.state_o !== 3'd0 || a_if.base_y !== 10'd0 || a_if.text_en !== 1'b0 || a_if.busy !== 1'b0) begin
            bad++; $display("FAIL abort state=%0d base_y=%0d text_en=%b busy=%b exp=0/0/0/0",
                            a_if.state_o, a_if.base_y, a_if.text_en, a_if.busy);
        end
        // Full hold length again after abort
        a_start();
        a_frames(84 + BOUNCE_FR + 119);
        total++; if (a_if.state_o !== 3'd3) begin bad++; $display("FAIL rehold_119 got=%0d exp=3", a_if.state_o); end
        a_frame();
        total++; if (a_if.state_o !== 3'd4) begin bad++; $display("FAIL rehold_120 got=%0d exp=4", a_if.state_o); end
    endtask

    task automatic test_rst_mid_blink();
        a_frames(5);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        total++; if (a_if.base_y !== 10'd0 || a_if.text_en !== 1'b0 || a_if.busy !== 1'b0 ||
                     a_if.done !== 1'b0 || a_if.state_o !== 3'd0) begin
            bad++; $display("FAIL async_rst base_y=%0d text_en=%b busy=%b done=%b state=%0d exp=0/0/0/0/0",
                            a_if.base_y, a_if.text_en, a_if.busy, a_if.done, a_if.state_o);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_fall5();
        @(posedge clk); #1 b_if.start = 1'b1;
        @(posedge clk); #1 b_if.start = 1'b0;
        for (int k = 0; k < 67; k++) b_frame();
        total++; if (b_if.base_y !== 10'd335 || b_if.state_o !== 3'd1) begin
            bad++; $display("FAIL fall5_67 base_y=%0d state=%0d exp=335/1", b_if.base_y, b_if.state_o);
        end
        b_frame();
        total++; if (b_if.base_y !== 10'd336 || b_if.state_o !== AFTER_DROP) begin
            bad++; $display("FAIL fall5_68 base_y=%0d state=%0d exp=336/%0d", b_if.base_y, b_if.state_o, AFTER_DROP);
        end
    endtask

    initial begin
        test_reset();
        test_drop();
`ifdef TEXT_ANIM_BOUNCE_EN
        test_bounce();
`endif
        test_hold_blink();
        test_restart();
        test_abort();
        test_rst_mid_blink();
        test_fall5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_anim_ctrl.md
# text_anim_ctrl

Frame-rate sequencer for the foreground text overlay. It sets the vertical position and visibility of the text block, running a one-shot intro: the text drops in, holds, blinks, then stays shown. It sits between the VGA timing generator, which supplies `next_frame`, and the text renderer, which consumes `base_y` and `text_en` and gates its `draw` output with `text_en`.

## Interface
- `START_Y`, 10'd0: base_y at start of drop; must be < TARGET_Y
- `TARGET_Y`, 10'd336: final resting base_y of line 0
- `FALL_STEP`, 10'd4: pixels added per frame during drop; must be ≥ 1
- `HOLD_FRAMES`, 8'd120: frames held steady before blinking; must be ≥ 1
- `BLINK_HALF`, 6'd8: frames per blink half-period (off or on); must be ≥ 1
- `BLINK_COUNT`, 3'd3: number of off/on blink cycles; must be ≥ 1
- `BOUNCE_H`, 10'd8: bounce height in pixels (only with TEXT_ANIM_BOUNCE_EN); must be even and ≤ TARGET_Y
- `clk` input 1: system/pixel clock
- `rst` input 1: asynchronous, active-high reset
- `next_frame` input 1: single-cycle pulse, once per frame, in vertical blank
- `start` input 1: single-cycle request to begin the intro sequence
- `abort` input 1: single-cycle request to return to IDLE
- `base_y` output 10: line-0 top Y coordinate for the renderer
- `text_en` output 1: text visible
- `busy` output 1: sequence in progress (DROP/BOUNCE/HOLD/BLINK)
- `done` output 1: single-cycle pulse on entry to SHOWN
- `state_o` output 3: current state encoding, for debug

## Operation
- State encoding: IDLE=0, DROP=1, BOUNCE=2, HOLD=3, BLINK=4, SHOWN=5.
- IDLE: base_y=START_Y, text_en=0. On `start` → DROP with text_en=1. base_y does not move on that edge, even if next_frame is high in the same cycle.
- DROP: on each next_frame, compute base_y+FALL_STEP in 11 bits.
  - If sum ≥ TARGET_Y: base_y←TARGET_Y, then → BOUNCE (macro on) or HOLD (macro off).
  - Else base_y←sum.
  - No overshoot or wrap is ever allowed.
- BOUNCE: base_y moves −2 per frame until it reaches TARGET_Y−BOUNCE_H, then +2 per frame until it reaches TARGET_Y, then → HOLD. This takes BOUNCE_H frames in total.
- HOLD: frame counter is cleared on entry. After HOLD_FRAMES next_frame pulses → BLINK.
- BLINK: text_en=0 for BLINK_HALF frames, then 1 for BLINK_HALF frames, repeated BLINK_COUNT times. After the final on-phase → SHOWN.
- SHOWN: base_y=TARGET_Y, text_en=1, busy=0. `done` pulses for one cycle on entry. On `start` → DROP with base_y←START_Y on the same edge (restart).
- `start` while busy=1: ignored.
- `abort` in any state → IDLE with base_y←START_Y and text_en←0, and counters cleared. If `abort` and `start` are both high in one cycle, abort wins.
- busy=1 exactly in DROP, BOUNCE, HOLD and BLINK.

## Timing
- All outputs are registered. Every update occurs on the clk edge where the triggering input is sampled high, so latency is 1 cycle.
- Reset values: base_y=START_Y, text_en=0, busy=0, done=0, state_o=0 (IDLE), all counters 0.
- Asserting `rst` mid-sequence returns to IDLE immediately (asynchronously); there is no resume.
- next_frame pulses seen in IDLE or SHOWN have no effect.
- State transitions triggered by next_frame take effect on the same edge. The entry frame is not counted toward HOLD or BLINK.

## Configuration
- `TEXT_ANIM_BOUNCE_EN` defined: the BOUNCE state exists, and DROP exits into BOUNCE.
- `TEXT_ANIM_BOUNCE_EN` undefined: BOUNCE logic is compiled out, DROP exits directly into HOLD, and state 2 is never reported on state_o.

## Test plan
- Reset with defaults → base_y=0, text_en=0, busy=0, state_o=0. Pulse `start`, then 83 frames → base_y=332. The 84th frame → base_y=336, state leaves DROP.
- FALL_STEP=5, TARGET_Y=336, macro off → after 67 frames base_y=335. The 68th frame clamps base_y to 336 and enters HOLD.
- Defaults, macro off → after 84 drop + 120 hold frames, enters BLINK with text_en=0. text_en toggles every 8 frames. After 48 blink frames, `done` pulses for 1 cycle, text_en=1 and busy=0.
- Macro on → after reaching 336, base_y runs 334, 332, 330, 328, 330, 332, 334, 336 over 8 frames, then enters HOLD.
- During HOLD, drive `start` and `abort` in the same cycle → IDLE next cycle, base_y=0, text_en=0. A `start` pulse during DROP leaves base_y on its normal sequence.
- In SHOWN, pulse `start` → base_y=0, text_en=1, busy=1 next cycle. Asserting `rst` mid-BLINK gives all outputs their reset values immediately.
